// File: rtl/norm_seq_pkg.sv
// Shared norm_pool definitions: datapath sizes, controller state encoding and
// the validity-mask helper used by norm_seq.
package norm_seq_pkg;
    localparam int DWIDTH      = 8;
    localparam int DESIGN_SIZE = 16;
    localparam int MASK_WIDTH  = 16;
    localparam int COL_W       = $clog2(DESIGN_SIZE) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // 0 or anything at/above DESIGN_SIZE selects every column.
    function automatic logic [MASK_WIDTH-1:0] mask_from_cols(input logic [COL_W-1:0] cols);
        logic [MASK_WIDTH-1:0] m;
        m = '1;
        if (cols != '0 && int'(cols) < DESIGN_SIZE)
            m = (MASK_WIDTH'(1) << cols) - MASK_WIDTH'(1);
        return m;
    endfunction
endpackage

// File: rtl/norm_seq_if.sv
// Row stream between the array-output buffer / norm stage and the norm sequencer.
interface norm_seq_if #(
    parameter int DWIDTH     = norm_seq_pkg::DWIDTH,
    parameter int MASK_WIDTH = norm_seq_pkg::MASK_WIDTH
);
    logic                  row_valid;
    logic                  row_ready;
    logic                  enable_norm;
    logic [DWIDTH-1:0]     mean;
    logic [DWIDTH-1:0]     inv_var;
    logic                  in_data_available;
    logic [MASK_WIDTH-1:0] validity_mask;
    logic                  out_data_available;

    modport master (
        input  row_valid, out_data_available,
        output row_ready, enable_norm, mean, inv_var, in_data_available, validity_mask
    );
    modport slave (
        output row_valid, out_data_available,
        input  row_ready, enable_norm, mean, inv_var, in_data_available, validity_mask
    );
endinterface

// File: rtl/norm_seq_param_table.sv
// Per-channel (mean, inv_var) register file: synchronous write, async read,
// reset to the identity normalisation (0, 1).
module norm_param_table
    import norm_seq_pkg::*;
#(
    parameter int DW    = DWIDTH,
    parameter int DEPTH = DESIGN_SIZE,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wmean,
    input  logic [DW-1:0] winv_var,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rmean,
    output logic [DW-1:0] rinv_var
);
    logic [DEPTH-1:0][DW-1:0] mean_mem;
    logic [DEPTH-1:0][DW-1:0] inv_mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mean_mem[i] <= '0;
                inv_mem[i]  <= DW'(1);
            end
        end else if (we) begin
            mean_mem[waddr] <= wmean;
            inv_mem[waddr]  <= winv_var;
        end
    end

    assign rmean    = mean_mem[raddr];
    assign rinv_var = inv_mem[raddr];
endmodule

// File: rtl/norm_seq.sv
// Sequencer for the norm stage: streams num_rows rows with per-channel parameters,
// caps in-flight rows, and counts returns into a single done pulse.
module norm_seq
    import norm_seq_pkg::*;
#(
    parameter int DWIDTH          = norm_seq_pkg::DWIDTH,
    parameter int DESIGN_SIZE     = norm_seq_pkg::DESIGN_SIZE,
    parameter int MASK_WIDTH      = norm_seq_pkg::MASK_WIDTH,
    parameter int ROW_CNT_WIDTH   = 8,
    parameter int MAX_OUTSTANDING = 4,
    localparam int AW             = $clog2(DESIGN_SIZE),
    localparam int RW             = ROW_CNT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DWIDTH-1:0] cfg_mean,
    input  logic [DWIDTH-1:0] cfg_inv_var,
    output logic              cfg_err,
    input  logic              start,
    input  logic              bypass,
    input  logic [RW-1:0]     num_rows,
    input  logic [AW:0]       num_cols,
    output logic              busy,
    output logic              done,
    norm_seq_if.master        norm_if
);
    state_t                state, state_nxt;
    logic [RW-1:0]         num_rows_q, issued, returned, outstanding;
    logic [RW-1:0]         issued_nxt, returned_nxt;
    logic                  bypass_q;
    logic [MASK_WIDTH-1:0] mask_q;
    logic [DWIDTH-1:0]     mean_q, inv_var_q, tbl_mean, tbl_inv_var;
    logic [AW-1:0]         rd_addr;
    logic                  start_ok, row_ready, hs, ret_ok;

    assign start_ok  = start && (state == IDLE);
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign row_ready = (state == RUN) && (outstanding < RW'(MAX_OUTSTANDING))
                       && (issued < num_rows_q);
    assign hs        = norm_if.row_valid && row_ready;
    // Returns with nothing in flight (or outside a job) are stray and dropped.
    assign ret_ok    = norm_if.out_data_available && busy && (outstanding != '0);

    assign issued_nxt   = issued + RW'(hs);
    assign returned_nxt = returned + RW'(ret_ok);

    // Start preloads channel 0; each handshake preloads the following row's channel.
    assign rd_addr = start_ok ? '0 : issued[AW-1:0] + AW'(1);

    norm_param_table #(.DW(DWIDTH), .DEPTH(DESIGN_SIZE)) u_table (
        .clk      (clk),
        .reset    (reset),
        .we       (cfg_we && !busy),
        .waddr    (cfg_addr),
        .wmean    (cfg_mean),
        .winv_var (cfg_inv_var),
        .raddr    (rd_addr),
        .rmean    (tbl_mean),
        .rinv_var (tbl_inv_var)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_rows == '0) ? DONE : RUN;
            RUN:     if (issued_nxt == num_rows_q) state_nxt = DRAIN;
            DRAIN:   if (returned_nxt == num_rows_q) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            num_rows_q  <= '0;
            issued      <= '0;
            returned    <= '0;
            outstanding <= '0;
            bypass_q    <= 1'b0;
            mask_q      <= '1;
            mean_q      <= '0;
            inv_var_q   <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                num_rows_q  <= num_rows;
                bypass_q    <= bypass;
                mask_q      <= MASK_WIDTH'(mask_from_cols(num_cols));
                issued      <= '0;
                returned    <= '0;
                outstanding <= '0;
                mean_q      <= tbl_mean;
                inv_var_q   <= tbl_inv_var;
            end else begin
                issued   <= issued_nxt;
                returned <= returned_nxt;
                if (hs && !ret_ok)
                    outstanding <= outstanding + RW'(1);
                else if (!hs && ret_ok)
                    outstanding <= outstanding - RW'(1);
                if (hs) begin
                    mean_q    <= tbl_mean;
                    inv_var_q <= tbl_inv_var;
                end
            end
        end
    end

    assign cfg_err                   = cfg_we && busy;
    assign norm_if.row_ready         = row_ready;
    assign norm_if.in_data_available = hs;
    assign norm_if.enable_norm       = busy && !bypass_q;
    assign norm_if.mean              = mean_q;
    assign norm_if.inv_var           = inv_var_q;
    assign norm_if.validity_mask     = mask_q;
endmodule
